// File: rtl/sync_ram_ws_if.sv
// Request/response bus of the wait-state RAM: request fields are qualified by cs,
// the response side carries ready, a one-cycle ack and the out-of-range flag.
interface sync_ram_ws_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) ();
    logic                    cs;
    logic                    read;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rdy;
    logic                    ack;
    logic                    err;

    modport master (
        output cs, read, address, wdata, be,
        input  rdata, rdy, ack, err
    );

    modport slave (
        input  cs, read, address, wdata, be,
        output rdata, rdy, ack, err
    );
endinterface

// File: rtl/sync_ram_ws.sv
// Single-port synchronous RAM with a programmable number of wait states,
// byte-enabled writes, and an error response for addresses beyond DEPTH.
module sync_ram_ws #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 2**14,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    sync_ram_ws_if.slave  bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  read_q, read_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic                  mem_we;

    // Range check uses the full captured address so nothing above DEPTH can alias.
    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign idx      = addr_q[IDX_W-1:0];
    assign mem_we   = (state_q == ACCESS) && !read_q && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        read_d  = read_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.cs) begin
                    read_d  = bus.read;
                    addr_d  = bus.address;
                    wdata_d = bus.wdata;
                    be_d    = bus.be;
                    if (WAIT_L == 4'd0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_L;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = DONE;
                err_d   = !in_range;
                if (read_q) begin
                    rdata_d = in_range ? mem[idx] : '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Captured request fields only matter once a request is accepted, so no reset.
    always_ff @(posedge clk) begin
        read_q  <= read_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.rdy   = (state_q == IDLE);
    assign bus.ack   = (state_q == DONE);
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
endmodule

// File: doc/sync_ram_ws.md
SYNC_RAM_WS -- requirements
Module: sync_ram_ws

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, data word width in bits; integer multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, address bus width.
REQ-003 SHALL have parameter DEPTH, default 2**14, number of words; DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, number of inserted wait states; range 0..15.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port cs  input  1  request strobe, sampled only in IDLE.
REQ-008 SHALL have port read  input  1  1 = read, 0 = write; qualified by cs.
REQ-009 SHALL have port address  input  ADDR_WIDTH  word address; qualified by cs.
REQ-010 SHALL have port wdata  input  DATA_WIDTH  write data; qualified by cs.
REQ-011 SHALL have port be  input  DATA_WIDTH/8  byte enables for writes; bit i covers wdata[8i+7:8i].
REQ-012 SHALL have port rdata  output  DATA_WIDTH  registered read data.
REQ-013 SHALL have port rdy  output  1  high only in IDLE: request will be accepted.
REQ-014 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-015 SHALL have port err  output  1  out-of-range flag, valid while ack=1.

Function
REQ-016 SHALL implement states IDLE, WAIT, ACCESS, DONE; rdy = (state==IDLE), decoded from state.
REQ-017 In IDLE with cs=1 at a rising edge (the accepting edge), SHALL capture read, address, wdata and be, then go to WAIT (counter=WAIT_CYCLES) or, if WAIT_CYCLES=0, to ACCESS.
REQ-018 In WAIT, SHALL decrement the counter each edge and go to ACCESS on the edge the counter reaches 0; WAIT occupies exactly WAIT_CYCLES cycles.
REQ-019 In ACCESS, SHALL perform the captured operation on that edge, go to DONE, and set ack=1 and err per REQ-022.
REQ-020 Writes SHALL update only the byte lanes with be[i]=1; be all-zero is a legal no-op write that still completes with ack.
REQ-021 Reads SHALL load rdata from memory; rdata SHALL hold its value until the next read completes and is unchanged by writes.
REQ-022 Address >= DEPTH SHALL set err=1 with ack: no memory write, no aliasing; a read loads rdata=0.
REQ-023 DONE SHALL last exactly one cycle with ack=1 and rdy=0, then return to IDLE; ack SHALL be 0 in every other state.
REQ-024 Latency: ack SHALL be high in the cycle following edge WAIT_CYCLES+1 after the accepting edge; minimum request-to-request period is WAIT_CYCLES+3 cycles.
REQ-025 cs during WAIT, ACCESS or DONE SHALL be ignored; changes to inputs after the accepting edge SHALL not affect the transaction.
REQ-026 cs held continuously high SHALL start a new transaction on every visit to IDLE.

Reset
REQ-027 rst_n=0 SHALL force, asynchronously: state=IDLE, counter=0, rdy=1, ack=0, err=0, rdata=0.
REQ-028 Memory contents SHALL NOT be cleared by reset; a reset asserted before the ACCESS edge aborts the transaction with no memory write and no ack.
REQ-029 The first accepting edge SHALL be the first rising edge with rst_n=1 and cs=1.

Verification (DATA_WIDTH=16, DEPTH=16384, WAIT_CYCLES=2 unless stated)
REQ-030 Write 0xA5C3 to 0x0010 with be=11, then read 0x0010 -> each ack one cycle, 3 edges after its accepting edge; read gives rdata=0xA5C3, err=0.
REQ-031 After REQ-030, write 0x1234 to 0x0010 with be=10, then read -> rdata=0x12C3.
REQ-032 Write 0xFFFF to 0x4000 -> ack with err=1; read 0x4000 -> rdata=0x0000, err=1; read 0x0000 -> prior content unchanged, err=0.
REQ-033 Write 0x5555 to 0x0020, drop rst_n during WAIT -> rdy=1, ack=0, rdata=0 immediately; read 0x0020 after release -> old content, not 0x5555.
REQ-034 cs held high for 20 cycles, alternating read toggles -> ack every 5 cycles, cs ignored while rdy=0.
REQ-035 WAIT_CYCLES=0: write then read 0x0001 -> ack 1 edge after each accepting edge, period 3 cycles, data correct.
